// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage behind the PC unit. It owns the sequential fetch address and
// issues one word read at a time to instruction memory over a req/ack
// handshake. Returned words are queued together with their PCs and handed to
// decode with valid/ready. A redirect flushes the queue and restarts fetch at
// the new target.
//
// Parameters
//   DEPTH     queue entries (power of two, 2..16)
//   RESET_PC  fetch address after reset
//
// Ports
//   Clk         clock, rising edge
//   Reset       synchronous active-high reset
//   Redirect    one-cycle flush/restart pulse
//   RedirectPC  new fetch target (low two bits ignored)
//   MemReq      registered read request
//   MemAddr     registered word address of the request
//   MemAck      one-cycle response strobe, MemRdata valid with it
//   MemRdata    instruction word from memory
//   InstrValid  queue head valid (registered)
//   Instr       instruction at queue head (registered)
//   InstrPC     PC of queue head (registered)
//   InstrReady  decode accepts head when InstrValid && InstrReady
//
// Optional build macro
//   IFQ_TRACE_EN  simulation-only trace of pushes and redirects
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic        MemReq,
   output logic [31:0] MemAddr,
   input  logic        MemAck,
   input  logic [31:0] MemRdata,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC,
   input  logic        InstrReady
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic             mem_req_d;
   logic [31:0]      mem_addr_d;
   logic [31:0]      redirect_pc;
   logic             take_c;

   logic             rsp_v_q;
   fetch_entry_t     rsp_q;
   fetch_entry_t     store_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] qcnt_q;
   logic [CNT_W-1:0] occ_c;
   logic             pop_c, refill_c, load_store_c, load_rsp_c, store_wr_c;

   assign redirect_pc = RedirectPC & 32'hFFFF_FFFC;

   // Occupancy counts the head register, the backing store and the word
   // captured from memory last cycle, so issue never outruns free space.
   assign occ_c = CNT_W'(InstrValid) + qcnt_q + CNT_W'(rsp_v_q);

   // FSM state and registered memory-side outputs
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         MemReq     <= 1'b0;
         MemAddr    <= 32'h0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         MemReq     <= mem_req_d;
         MemAddr    <= mem_addr_d;
      end
   end

   // Next-state and request generation
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_req_d  = MemReq;
      mem_addr_d = MemAddr;
      take_c     = 1'b0;

      if (Redirect) begin
         fetch_pc_d = redirect_pc;
      end

      case (state_q)
         ST_IDLE: begin
            mem_req_d = 1'b0;
            if (!Redirect && (occ_c < CNT_W'(DEPTH))) begin
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (Redirect) begin
               // A same-cycle ack retires the request; otherwise its ack is still owed.
               mem_req_d = 1'b0;
               state_d   = MemAck ? ST_IDLE : ST_DRAIN;
            end else if (MemAck) begin
               take_c     = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               mem_req_d  = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // The owed ack is swallowed even if another redirect lands with it.
            mem_req_d = 1'b0;
            if (MemAck) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Head register refills from the store first, else straight from the capture stage
   assign pop_c        = InstrValid && InstrReady;
   assign refill_c     = !InstrValid || pop_c;
   assign load_store_c = refill_c && (qcnt_q != CNT_W'(0));
   assign load_rsp_c   = refill_c && (qcnt_q == CNT_W'(0)) && rsp_v_q;
   assign store_wr_c   = rsp_v_q && !load_rsp_c && !Reset && !Redirect;

   // Capture stage, head register and store bookkeeping
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rsp_v_q    <= 1'b0;
         rsp_q      <= '0;
         InstrValid <= 1'b0;
         Instr      <= 32'h0;
         InstrPC    <= 32'h0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         qcnt_q     <= '0;
      end else if (Redirect) begin
         rsp_v_q    <= 1'b0;
         InstrValid <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         qcnt_q     <= '0;
      end else begin
         rsp_v_q <= take_c;
         if (take_c) begin
            rsp_q <= '{pc: fetch_pc_q, word: MemRdata};
         end

         if (load_store_c) begin
            InstrValid <= 1'b1;
            InstrPC    <= store_q[rd_ptr_q].pc;
            Instr      <= store_q[rd_ptr_q].word;
            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
         end else if (load_rsp_c) begin
            InstrValid <= 1'b1;
            InstrPC    <= rsp_q.pc;
            Instr      <= rsp_q.word;
         end else if (refill_c) begin
            InstrValid <= 1'b0;
         end

         if (store_wr_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         qcnt_q <= qcnt_q + CNT_W'(store_wr_c) - CNT_W'(load_store_c);
      end
   end

   // Backing store data (no reset needed, guarded by qcnt)
   always_ff @(posedge Clk) begin
      if (store_wr_c) begin
         store_q[wr_ptr_q] <= rsp_q;
      end
   end

`ifdef IFQ_TRACE_EN
   // Simulation trace of accepted fetches and redirects
   always @(posedge Clk) begin
      if (!Reset) begin
         if (take_c) begin
            $display("Fetch: PC=%8X Instr=%8X", fetch_pc_q, MemRdata);
         end
         if (Redirect) begin
            $display("Redirect: from=%8X to=%8X", fetch_pc_q, redirect_pc);
         end
      end
   end
`else
`endif

endmodule
